// File: rtl/bcd_pkg.sv
// Shared BCD helpers: digit type, adjust constants,
// width helper and converter state encoding.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd8;
  localparam bcd_digit_t BCD_ADJ_VAL    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd2bin_state_e;

  function automatic logic bcd_is_valid(input bcd_digit_t n);
    return n <= 4'd9;
  endfunction

  // Smallest w with 2^w >= 10^d, i.e. ceil(d*log2(10)).
  function automatic int bin_width_for_digits(input int d);
    longint unsigned p10;
    longint unsigned p2;
    int w;
    p10 = 64'd1;
    for (int i = 0; i < d; i++) p10 = p10 * 64'd10;
    p2 = 64'd1;
    w  = 0;
    while (p2 < p10) begin
      p2 = p2 * 64'd2;
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Handshake bundle for the BCD-to-binary converter:
// BCD word in, binary result plus error flags out.
interface bcd2bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int N      = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIGITS*4-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          bin_out;
  logic                  err_digit;
  logic                  err_ovf;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out,
    input  err_digit, err_ovf
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out,
    output err_digit, err_ovf
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit reverse double dabble correction:
// a nibble >= 8 after the shift gets 3 subtracted.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);

  // Cannot underflow: the subtract only fires for d_i >= 8.
  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_ADJ_THRESH) d_o = d_i - BCD_ADJ_VAL;
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, reverse double
// dabble with one shift-and-adjust per clock.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int N      = bin_width_for_digits(DIGITS)
) (
  input logic          clk,
  input logic          rst_n,
  bcd2bin_seq_if.slave bus
);

  localparam int BW = DIGITS * 4;
  localparam int WW = BW + N;
  localparam int CW = $clog2(N + 1);

  bcd2bin_state_e state_q, state_d;
  logic [WW-1:0]  w_q, w_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   bin_q, bin_d;
  logic           ed_q, ed_d;
  logic           eo_q, eo_d;

  logic [WW-1:0]  w_sh;
  logic [WW-1:0]  w_adj;
  logic           bad_digit;

  assign w_sh = w_q >> 1;
  assign w_adj[N-1:0] = w_sh[N-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (w_sh[N+4*g +: 4]),
      .d_o (w_adj[N+4*g +: 4])
    );
  end

  // Flag any input nibble outside 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_is_valid(bus.bcd_in[4*i +: 4])) bad_digit = 1'b1;
    end
  end

  // Next-state, work register and result capture.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ed_d    = ed_q;
    eo_d    = eo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          w_d   = {bus.bcd_in, {N{1'b0}}};
          cnt_d = '0;
          if (bad_digit) begin
            ed_d    = 1'b1;
            eo_d    = 1'b0;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        w_d   = w_adj;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          bin_d   = w_adj[N-1:0];
          eo_d    = |w_adj[WW-1:N];
          ed_d    = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ed_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ed_q    <= ed_d;
      eo_q    <= eo_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bin_out   = bin_q;
  assign bus.err_digit = ed_q;
  assign bus.err_ovf   = eo_q;

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Sequential BCD-to-binary converter using reverse double dabble, one shift per clock. It is the decode-side counterpart of our combinational binary-to-BCD block. It sits behind the decimal-digit parser (digits packed as BCD nibbles) and feeds binary operands into the puzzle datapath. It uses valid/ready handshakes on both sides and processes one conversion at a time.

Parameters:
DIGITS, 4, number of BCD input digits (nibbles).
N, 14, binary output width; must be >= 1. The default covers 0..9999.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  BCD word valid
in_ready  out  1  converter can accept a word
bcd_in  in  DIGITS*4  packed BCD; digit 0 in bits [3:0]
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
bin_out  out  N  binary result
err_digit  out  1  some input nibble was > 9
err_ovf  out  1  value did not fit in N bits

Behaviour:
- Reset (asynchronous, rst_n low):
  - State is IDLE.
  - in_ready=1, out_valid=0, bin_out=0, err_digit=0, err_ovf=0.
  - Shift counter and work register are 0.
- Work register: W of DIGITS*4+N bits, laid out as {bcd field, bin field}.
- State IDLE:
  - in_ready=1 (registered, state==IDLE).
  - On in_valid&&in_ready, latch W = {bcd_in, N'b0} and clear the counter.
  - If any nibble of bcd_in is > 9: set err_digit=1, bin_out=0, err_ovf=0, go to DONE. Shifting is skipped.
  - Otherwise go to SHIFT.
- State SHIFT: one iteration per cycle, N iterations total.
  - Step 1: W = W >> 1 (logical).
  - Step 2: each bcd-field nibble that is >= 8 has 3 subtracted, all digits in parallel on the shifted value.
  - The counter increments each iteration. After iteration N-1, go to DONE.
  - On the DONE transition: bin_out = W bin field; err_ovf = (bcd field != 0); err_digit=0.
- State DONE:
  - out_valid=1. bin_out and the error flags are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency, from the accepting edge to out_valid high:
  - Valid input: N+1 cycles.
  - Invalid digit: 1 cycle.
- Throughput: one conversion per N+2 cycles minimum. There is no input-while-busy acceptance (in_ready=0 in SHIFT and DONE).
- Overflow: bin_out is the value mod 2^N, and err_ovf=1.
- in_valid while busy: ignored. The upstream block must hold the word until in_ready.
- bcd_in is sampled only on the accepting edge; later changes have no effect.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values. The pending result is discarded and never presented.
- Arithmetic width: the nibble subtract is 4-bit. A nibble >= 8 minus 3 cannot underflow.
- Counter width: $clog2(N+1).

Decomposition:
- bcd_pkg holds:
  - bcd_digit_t (logic [3:0]).
  - BCD_ADJ_THRESH=8 and BCD_ADJ_VAL=3.
  - Function bcd_is_valid(nibble).
  - Function bin_width_for_digits(d) returning the ceiling of d*log2(10). bin2bcd and bcd2bin_seq share this.
  - State enum bcd2bin_state_e {IDLE, SHIFT, DONE}.
- One sub-module: bcd_digit_adj. It is a combinational per-nibble ">=8 → -3" block, instantiated DIGITS times via generate. Everything else stays in the top module.

Test Plan:
- bcd_in=0x9999, out_ready=1 -> out_valid 15 cycles after accept; bin_out=9999; err_digit=0; err_ovf=0.
- bcd_in=0x0000, then back-to-back bcd_in=0x0001 -> outputs 0 then 1; second accept occurs exactly 1 cycle after the first out handshake; in_ready=0 throughout SHIFT.
- bcd_in=0x1234, out_ready held low for 5 cycles in DONE -> bin_out=1234 and out_valid stay stable; a new in_valid=1 is not accepted until after the out handshake.
- bcd_in=0x12A4 -> out_valid 1 cycle after accept; err_digit=1; bin_out=0; err_ovf=0.
- N=10, DIGITS=4, bcd_in=0x1025 -> bin_out=1 (1025 mod 1024); err_ovf=1.
- rst_n pulsed low at SHIFT iteration 5 of 0x0512 -> in_ready=1 and out_valid=0 immediately; no stale result; next conversion of 0x0042 gives 42.
